// File: rtl/leitor_de_registradores.sv
// Sequential read-out engine for the register bank's second read port: walks a
// wrap-around index range and streams {index, value}. Optional XOR checksum: LEITOR_CHECKSUM_EN.
module leitor_de_registradores #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] first,
    input  logic [AW-1:0] last,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2} state_t;

    state_t        state;
    logic [AW-1:0] last_q;
    logic          start_acc;
    logic          word_acc;
    logic [AW-1:0] addr_next;

    // Stream handshake: a word transfers on every posedge where out_valid && out_ready;
    // out_data/out_index never change while out_valid=1 and out_ready=0.
    assign start_acc = (state == IDLE) && start && !busy;
    assign word_acc  = (state == SEND) && out_ready;
    assign addr_next = AW'((32'(rd_addr) + 32'd1) % NREG);
    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last_q    <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy stays up through the done cycle, so a start right then is dropped
                    busy <= 1'b0;
                    if (start_acc) begin
                        rd_addr <= first;
                        last_q  <= last;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    out_data  <= rd_data;
                    out_index <= rd_addr;
                    out_valid <= 1'b1;
                    rd_addr   <= addr_next;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_index == last_q) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_data  <= rd_data;
                            out_index <= rd_addr;
                            rd_addr   <= addr_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LEITOR_CHECKSUM_EN
    logic [DW-1:0] cksum_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cksum_q <= '0;
        end else if (start_acc) begin
            cksum_q <= '0;
        end else if (word_acc) begin
            cksum_q <= cksum_q ^ out_data;
        end
    end

    assign checksum = cksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_leitor_de_registradores.sv
// Bench for leitor_de_registradores: transaction-level model of the dump stream
// checked every cycle, plus literal expectations per directed scenario.
module tb_leitor_de_registradores;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          start;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic [1:0]    dbg_state;

    logic [DW-1:0] bank [32];
    assign rd_data = bank[rd_addr];

    leitor_de_registradores #(.NREG(32), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset), .start(start), .first(first), .last(last),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .busy(busy), .done(done), .checksum(checksum), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: expected index queue and the word currently presented
    logic [AW-1:0] exp_q[$];
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_ck = '0;
    bit m_busy = 0, m_done = 0, m_valid = 0, m_load = 0;
    bit st_acc, acc, n_done;
    int n_words;
    logic [AW-1:0] log_idx[$];
    logic [DW-1:0] log_dat[$];

    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                chk("busy", {31'b0, busy}, {31'b0, m_busy});
                chk("done", {31'b0, done}, {31'b0, m_done});
                chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
`ifdef LEITOR_CHECKSUM_EN
                chk("checksum", checksum, m_ck);
`else
                chk("checksum", checksum, 32'h0);
`endif
                if (m_valid && exp_q.size() > 0) begin
                    chk("out_index", 32'(out_index), 32'(exp_q[0]));
                    chk("out_data", out_data, m_data);
                end
                if (out_valid && out_ready) begin
                    log_idx.push_back(out_index);
                    log_dat.push_back(out_data);
                end
            end
            #1;
            if (reset) begin
                m_busy = 0; m_done = 0; m_valid = 0; m_load = 0;
                m_data = '0; m_ck = '0;
                exp_q.delete();
            end else begin
                st_acc = start && !m_busy;
                acc    = m_valid && out_ready;
                n_done = acc && (exp_q.size() == 1);
                if (m_done) m_busy = 0;
                if (acc) begin
                    m_ck = m_ck ^ m_data;
                    void'(exp_q.pop_front());
                    if (exp_q.size() > 0) m_data = bank[exp_q[0]];
                    else m_valid = 0;
                end
                if (m_load) begin
                    m_data  = bank[exp_q[0]];
                    m_valid = 1;
                    m_load  = 0;
                end
                if (st_acc) begin
                    n_words = int'(AW'(last - first)) + 1;
                    for (int k = 0; k < n_words; k++) exp_q.push_back(AW'(int'(first) + k));
                    m_busy = 1;
                    m_load = 1;
                    m_ck   = '0;
                end
                m_done = n_done;
            end
        end
    end

    // driver tasks
    task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(posedge clock); #2;
        start = 1'b1; first = f; last = l; out_ready = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int mode);
        bit got = 0;
        int cyc = 0;
        while (!got && cyc < 400) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(negedge clock);
            if (done) got = 1;
            @(posedge clock); #2;
            cyc++;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", cyc);
        end
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_dat.delete();
    endtask

    initial begin
        bit found;
        reset = 1'b1; start = 1'b0; first = '0; last = '0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) bank[i] = i * 32'h01010101;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        chk_en = 1;

        @(negedge clock);
        chk("rst_rd_addr", 32'(rd_addr), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_index", 32'(out_index), 32'h0);
        chk("rst_checksum", checksum, 32'h0);

        // full dump 0..31, ready high
        clear_log();
        pulse_start(5'd0, 5'd31);
        wait_done(0);
        chk("full_count", 32'(log_idx.size()), 32'd32);
        if (log_idx.size() == 32) begin
            chk("full_idx31", 32'(log_idx[31]), 32'd31);
            chk("full_dat5", log_dat[5], 32'h05050505);
            chk("full_dat31", log_dat[31], 32'h1F1F1F1F);
        end
`ifdef LEITOR_CHECKSUM_EN
        chk("full_cksum", checksum, 32'h0);
`endif

        // wrap range 30..1
        clear_log();
        pulse_start(5'd30, 5'd1);
        wait_done(0);
        chk("wrap_count", 32'(log_idx.size()), 32'd4);
        if (log_idx.size() == 4) begin
            chk("wrap_idx0", 32'(log_idx[0]), 32'd30);
            chk("wrap_idx1", 32'(log_idx[1]), 32'd31);
            chk("wrap_idx2", 32'(log_idx[2]), 32'd0);
            chk("wrap_idx3", 32'(log_idx[3]), 32'd1);
        end

        // single word 7..7
        clear_log();
        pulse_start(5'd7, 5'd7);
        wait_done(0);
        chk("single_count", 32'(log_idx.size()), 32'd1);
        if (log_idx.size() == 1) chk("single_dat", log_dat[0], 32'h07070707);
`ifdef LEITOR_CHECKSUM_EN
        chk("single_cksum", checksum, 32'h07070707);
`endif

        // stalled consumer
        clear_log();
        pulse_start(5'd0, 5'd31);
        wait_done(1);
        chk("stall_count", 32'(log_idx.size()), 32'd32);
        if (log_idx.size() == 32) chk("stall_idx17", 32'(log_idx[17]), 32'd17);

        // start mid-dump is ignored
        clear_log();
        pulse_start(5'd0, 5'd31);
        repeat (6) @(posedge clock);
        #2 start = 1'b1; first = 5'd16; last = 5'd3;
        @(posedge clock); #2 start = 1'b0;
        wait_done(0);
        chk("ignore_count", 32'(log_idx.size()), 32'd32);
        if (log_idx.size() == 32) chk("ignore_idx0", 32'(log_idx[0]), 32'd0);

        // reset while word 5 is presented
        pulse_start(5'd0, 5'd31);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (out_valid && out_index == 5'd5) found = 1;
        end
        chk("reset_reach_word5", {31'b0, found}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #2 reset = 1'b0;
        @(negedge clock);
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_rd_addr", 32'(rd_addr), 32'd0);
        chk("abort_out_data", out_data, 32'd0);
        chk("abort_out_index", 32'(out_index), 32'd0);
        clear_log();
        pulse_start(5'd0, 5'd31);
        wait_done(0);
        chk("after_reset_count", 32'(log_idx.size()), 32'd32);
        if (log_idx.size() == 32) chk("after_reset_idx0", 32'(log_idx[0]), 32'd0);

        // bank write on the negedge before reg[10] is captured
        clear_log();
        pulse_start(5'd8, 5'd12);
        repeat (3) @(negedge clock);
        bank[10] = 32'hDEADBEEF;
        wait_done(0);
        chk("write_count", 32'(log_idx.size()), 32'd5);
        if (log_idx.size() == 5) begin
            chk("write_idx2", 32'(log_idx[2]), 32'd10);
            chk("write_dat2", log_dat[2], 32'hDEADBEEF);
        end
`ifdef LEITOR_CHECKSUM_EN
        chk("write_cksum", checksum, 32'hD8ABB8E9);
`endif

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/leitor_de_registradores.md
# leitor_de_registradores

Sequential read-out engine for the 32×32 register bank. It sits on the bank's second read port and is used for debug dumps and for context snapshots. A `start` pulse makes it walk a programmable, wrap-around range of register indices. It returns each register value, tagged with its index, over a valid/ready stream at up to one word per cycle. The bank's write port is untouched: this block is read-only.

## Interface
Parameters:
- `NREG`, 32: number of registers in the bank; must be a power of two.
- `AW`, 5: index width, log2(NREG).
- `DW`, 32: register data width.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a dump; ignored while `busy`.
- `first`  in  AW  first index to read; sampled on accepted `start`.
- `last`  in  AW  final index to read; sampled on accepted `start`.
- `rd_addr`  out  AW  index driven to the bank read port (registered).
- `rd_data`  in  DW  bank read data; combinational from `rd_addr`.
- `out_valid`  out  1  `out_data`/`out_index` hold a word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  DW  captured register value.
- `out_index`  out  AW  index of `out_data`.
- `busy`  out  1  high from accepted `start` until the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse after the final word is accepted.
- `checksum`  out  DW  XOR of all words in the dump (see Configuration).

## Operation
- FSM states: IDLE, LOAD, SEND.
- **IDLE:** `busy`=0.
  - On `start`: `rd_addr`<=`first`; latch `last`; `busy`<=1; go to LOAD.
- **LOAD** (one cycle):
  - Capture `out_data`<=`rd_data` and `out_index`<=`rd_addr`.
  - Set `out_valid`<=1 and `rd_addr`<=`rd_addr`+1 (mod NREG).
  - Go to SEND.
- **SEND:** `out_valid`=1, and `out_data`/`out_index` stay stable while `out_ready`=0.
  - On `out_ready` with `out_index`==latched `last`: `out_valid`<=0, `done`<=1 for one cycle, `busy`<=0 in the following cycle, go to IDLE.
  - On `out_ready` with `out_index`!=`last`: capture the next word from `rd_data`, update `out_index`, increment `rd_addr`, stay in SEND. This gives back-to-back words with no bubble.
- Index arithmetic is modulo NREG.
  - Words transferred = ((`last`−`first`) mod NREG)+1.
  - `first`==`last` gives exactly one word.
  - `first`=30, `last`=1 gives indices 30, 31, 0, 1.
  - A full dump of NREG words is `first`=k, `last`=k−1.
- Coherence: each word is the bank contents at its capture posedge. Bank writes on the negedge before capture are visible. No atomic snapshot is guaranteed.
- `start` while `busy`=1 is ignored; there is no queueing.

## Timing
- Reset values: `out_valid`=0, `done`=0, `busy`=0, `rd_addr`=0, `out_data`=0, `out_index`=0, `checksum`=0; FSM in IDLE.
- `start` at cycle T: LOAD at T+1, `out_valid`=1 from T+2.
- With `out_ready` held high, word n is accepted at cycle T+2+n.
- The final accept at cycle A gives `done`=1 at A+1. A new `start` is accepted from A+2.
- `reset` in any state aborts immediately. The next cycle shows reset values, with no `done` pulse and no partial-word hold.
- Critical path: `rd_addr` register → bank read mux → `out_data` register. There is no combinational path from `out_ready` to `rd_addr`.

## Configuration
- `LEITOR_CHECKSUM_EN` defined:
  - `checksum` clears on accepted `start`.
  - It XOR-accumulates every word at acceptance (`out_valid`&&`out_ready`).
  - It is final and stable from the `done` cycle until the next accepted `start`.
- Not defined: `checksum` is tied to 0 and no accumulator is synthesized.

## Test plan
- Bank preloaded reg[i]=i×0x01010101; `first`=0, `last`=31, `out_ready`=1 → 32 consecutive words with indices 0..31 and correct data; `done` exactly 1 cycle after word 31; with `LEITOR_CHECKSUM_EN`, `checksum` equals the XOR of the 32 values.
- `first`=30, `last`=1 → indices 30, 31, 0, 1 and then `done`; `first`=`last`=7 → single word reg[7], then `done`.
- `out_ready` toggling 1,0,0,1,… → `out_data`/`out_index` stable while stalled; no word dropped or duplicated; acceptance count = 32.
- Second `start` pulsed mid-dump with different `first` → ignored; the original range completes unchanged.
- `reset` asserted while in SEND at word 5 → next cycle all outputs at reset values, no `done`; a fresh `start` afterwards dumps the full range from `first`.
- Bank write of 0xDEADBEEF to reg[10] on the negedge before reg[10]'s capture → dumped value is 0xDEADBEEF.
